mem_access_ctrl: RTL

- Load/store sequencer between the EX/MEM pipeline register and data_mem.
- Accepts one memory request at a time and handles natural alignment and range checking.
- Drives data_mem's doubleword-indexed MemRead/MemWrite interface; sub-doubleword stores use read-modify-write.
- Returns a single-cycle response: load data, sign- or zero-extended, or a store acknowledge.
- Holds busy high so hazard logic can stall the pipeline.

---
 rtl/mem_access_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// mem_access_ctrl : load/store sequencer to data_mem, RMW for narrow stores
// Revision        : 1.0
// ============================================================================
module mem_access_ctrl #(
   parameter int WORD      = 64,
   parameter int MEM_DEPTH = 32,
   parameter int RD_LAT    = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [1:0]      req_size,
   input  logic            req_signed,
   input  logic [WORD-1:0] req_addr,
   input  logic [WORD-1:0] req_wdata,
   output logic            resp_valid,
   output logic [WORD-1:0] resp_data,
   output logic            resp_fault,
   output logic            busy,
   output logic            MemRead,
   output logic            MemWrite,
   output logic [WORD-1:0] mem_address,
   output logic [WORD-1:0] mem_write_data,
   input  logic [WORD-1:0] mem_read_data
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_WAIT  = 3'd2,
      S_WR    = 3'd3,
      S_RESP  = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   localparam logic [WORD-1:0] c_ADDR_LIMIT = WORD'(MEM_DEPTH * 8);
   localparam logic [1:0]      c_WAIT_INIT  = 2'(RD_LAT - 1);

   state_t          r_state;
   logic            r_req_ready;
   logic            r_busy;
   logic            r_resp_valid;
   logic            r_resp_fault;
   logic [WORD-1:0] r_resp_data;
   logic            r_mem_read;
   logic            r_mem_write;
   logic [WORD-1:0] r_mem_address;
   logic [WORD-1:0] r_mem_write_data;
   logic            r_write;
   logic [1:0]      r_size;
   logic            r_signed;
   logic [2:0]      r_off;
   logic [WORD-1:0] r_wdata;
   logic [1:0]      r_wait_cnt;

   logic [2:0]      w_align_mask;
   logic            w_fault;
   logic [5:0]      w_shift;
   logic [WORD-1:0] w_lmask;
   logic [WORD-1:0] w_lane;
   logic [WORD-1:0] w_load;
   logic [WORD-1:0] w_merged;

   function automatic logic [WORD-1:0] lane_mask(input logic [1:0] size);
      case (size)
         2'd0:    lane_mask = {{(WORD-8){1'b0}},  8'hFF};
         2'd1:    lane_mask = {{(WORD-16){1'b0}}, 16'hFFFF};
         2'd2:    lane_mask = {{(WORD-32){1'b0}}, 32'hFFFF_FFFF};
         default: lane_mask = '1;
      endcase
   endfunction

   always_comb begin
      w_align_mask = 3'b000;
      case (req_size)
         2'd0:    w_align_mask = 3'b000;
         2'd1:    w_align_mask = 3'b001;
         2'd2:    w_align_mask = 3'b011;
         default: w_align_mask = 3'b111;
      endcase
   end

   assign w_fault = ((req_addr[2:0] & w_align_mask) != 3'b000) || (req_addr >= c_ADDR_LIMIT);

   // Lane position inside the captured doubleword, little-endian.
   assign w_shift  = {r_off, 3'b000};
   assign w_lmask  = lane_mask(r_size);
   assign w_lane   = mem_read_data >> w_shift;
   assign w_merged = (mem_read_data & ~(w_lmask << w_shift)) | ((r_wdata & w_lmask) << w_shift);

   always_comb begin
      w_load = w_lane;
      case (r_size)
         2'd0:    w_load = {{(WORD-8){r_signed & w_lane[7]}},   w_lane[7:0]};
         2'd1:    w_load = {{(WORD-16){r_signed & w_lane[15]}}, w_lane[15:0]};
         2'd2:    w_load = {{(WORD-32){r_signed & w_lane[31]}}, w_lane[31:0]};
         default: w_load = w_lane;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state          <= S_IDLE;
         r_req_ready      <= 1'b1;
         r_busy           <= 1'b0;
         r_resp_valid     <= 1'b0;
         r_resp_fault     <= 1'b0;
         r_resp_data      <= '0;
         r_mem_read       <= 1'b0;
         r_mem_write      <= 1'b0;
         r_mem_address    <= '0;
         r_mem_write_data <= '0;
         r_write          <= 1'b0;
         r_size           <= 2'd0;
         r_signed         <= 1'b0;
         r_off            <= 3'd0;
         r_wdata          <= '0;
         r_wait_cnt       <= 2'd0;
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_fault <= 1'b0;
         r_resp_data  <= '0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_write       <= req_write;
                  r_size        <= req_size;
                  r_signed      <= req_signed;
                  r_off         <= req_addr[2:0];
                  r_wdata       <= req_wdata;
                  r_mem_address <= {req_addr[WORD-1:3], 3'b000};
                  r_req_ready   <= 1'b0;
                  r_busy        <= 1'b1;
                  if (w_fault) begin
                     r_state      <= S_FAULT;
                     r_resp_valid <= 1'b1;
                     r_resp_fault <= 1'b1;
                  end else if (req_write && (req_size == 2'd3)) begin
                     r_state          <= S_WR;
                     r_mem_write      <= 1'b1;
                     r_mem_write_data <= req_wdata;
                  end else begin
                     r_state    <= S_RD;
                     r_mem_read <= 1'b1;
                  end
               end
            end
            S_RD: begin
               r_state    <= S_WAIT;
               r_wait_cnt <= c_WAIT_INIT;
            end
            S_WAIT: begin
               if (r_wait_cnt != 2'd0) begin
                  r_wait_cnt <= r_wait_cnt - 2'd1;
               end else if (r_write) begin
                  r_state          <= S_WR;
                  r_mem_write      <= 1'b1;
                  r_mem_write_data <= w_merged;
               end else begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_data  <= w_load;
               end
            end
            S_WR: begin
               r_state      <= S_RESP;
               r_resp_valid <= 1'b1;
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready      = r_req_ready;
   assign busy           = r_busy;
   assign resp_valid     = r_resp_valid;
   assign resp_fault     = r_resp_fault;
   assign resp_data      = r_resp_data;
   assign MemRead        = r_mem_read;
   assign MemWrite       = r_mem_write;
   assign mem_address    = r_mem_address;
   assign mem_write_data = r_mem_write_data;

endmodule
`default_nettype wire
